// File: rtl/muldiv_seq_ctrl_pkg.sv
// Package: muldiv_seq_ctrl_pkg
// Shared constants and helpers for the multi-cycle MULT/DIV sequencer.
//   W         operand width (fixed to 32 for this core)
//   CNT_W     iteration counter width
//   CNT_LAST  counter value of the final ITER cycle
//   FN_ADD / FN_SUB  ALU function codes driven on alu_funct
//   abs_val() magnitude of a two's-complement value when signed mode is on

package muldiv_seq_ctrl_pkg;

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;

    // Local negate: no ALU cycle is spent producing operand magnitudes.
    function automatic logic [W-1:0] abs_val(input logic [W-1:0] v, input logic en);
        return (en && v[W-1]) ? (~v + {{(W-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/muldiv_seq_ctrl.sv
// Module: muldiv_seq_ctrl
// Multi-cycle MULT/DIV sequencer. Borrows the shared EX-stage ALU (ADD/SUB)
// for 32 shift-add (MULT) or restoring-subtract (DIV) iterations, holds the
// HI/LO results and stalls the pipeline through busy.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               1-cycle request, sampled only while idle
//   op_div, op_signed   0=MULT/1=DIV, signed request
//   data_rs, data_rt    multiplicand/dividend, multiplier/divisor
//   alu_a, alu_b        ALU operands while busy (0 when idle)
//   alu_funct           FN_ADD or FN_SUB (FN_ADD when idle)
//   alu_res             ALU result, bit W = carry-out (SUB: 1 means a >= b)
//   busy                high from LOAD through the last ITER/FIX cycle
//   done                1-cycle pulse, hi/lo valid in the same cycle
//   div_zero            sticky until next LOAD; DIV with data_rt == 0
//   hi, lo              MULT high/low word, DIV remainder/quotient
//
// Configuration: define MULDIV_SIGNED_EN to honour op_signed (adds FIX_LO and
// FIX_HI sign-correction cycles when the result is negative). Without it all
// operations are unsigned and the FIX states are never entered.

module muldiv_seq_ctrl
    import muldiv_seq_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op_div,
    input  logic         op_signed,
    input  logic [W-1:0] data_rs,
    input  logic [W-1:0] data_rt,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [5:0]   alu_funct,
    input  logic [W:0]   alu_res,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIter,
        StFixLo,
        StFixHi,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       hi_q, hi_d;
    logic [W-1:0]       lo_q, lo_d;
    // rs_q: raw rs captured at start. opnd_q: raw rt at start, then the
    // iteration operand (|multiplicand| or |divisor|) from LOAD onwards.
    logic [W-1:0]       rs_q, rs_d;
    logic [W-1:0]       opnd_q, opnd_d;
    logic               div_q, div_d;
    logic               div_zero_q, div_zero_d;
    logic               sgn;
    logic               fix_needed;

`ifdef MULDIV_SIGNED_EN
    logic               sgn_q, sgn_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;

    assign sgn        = sgn_q;
    assign fix_needed = neg_lo_q | neg_hi_q;
`else
    logic               unused_op_signed;

    assign unused_op_signed = op_signed;
    assign sgn              = 1'b0;
    assign fix_needed       = 1'b0;
`endif

    // Divide step: {r, hi, lo} shifted left by one.
    logic               r_bit;
    logic [W-1:0]       hi_sh;
    logic [W-1:0]       lo_sh;

    always_comb begin
        r_bit = hi_q[W-1];
        hi_sh = {hi_q[W-2:0], lo_q[W-1]};
        lo_sh = {lo_q[W-2:0], 1'b0};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        rs_d       = rs_q;
        opnd_d     = opnd_q;
        div_d      = div_q;
        div_zero_d = div_zero_q;
`ifdef MULDIV_SIGNED_EN
        sgn_d      = sgn_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
`endif
        alu_a      = '0;
        alu_b      = '0;
        alu_funct  = FN_ADD;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    rs_d    = data_rs;
                    opnd_d  = data_rt;
                    div_d   = op_div;
`ifdef MULDIV_SIGNED_EN
                    sgn_d   = op_signed;
`endif
                    state_d = StLoad;
                end
            end

            StLoad: begin
                busy       = 1'b1;
                hi_d       = '0;
                cnt_d      = '0;
                div_zero_d = 1'b0;
                if (div_q) begin
                    lo_d   = abs_val(rs_q, sgn);
                    opnd_d = abs_val(opnd_q, sgn);
                end else begin
                    lo_d   = abs_val(opnd_q, sgn);
                    opnd_d = abs_val(rs_q, sgn);
                end
`ifdef MULDIV_SIGNED_EN
                // Quotient/product sign from both operands; remainder follows rs.
                neg_lo_d = sgn_q & (rs_q[W-1] ^ opnd_q[W-1]);
                neg_hi_d = sgn_q & (div_q ? rs_q[W-1] : (rs_q[W-1] ^ opnd_q[W-1]));
`endif
                if (div_q && (opnd_q == '0)) begin
                    div_zero_d = 1'b1;
                    hi_d       = rs_q;
                    lo_d       = '1;
`ifdef MULDIV_SIGNED_EN
                    neg_lo_d   = 1'b0;
                    neg_hi_d   = 1'b0;
`endif
                    state_d    = StDone;
                end else begin
                    state_d    = StIter;
                end
            end

            StIter: begin
                busy  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (div_q) begin
                    alu_a     = hi_sh;
                    alu_b     = opnd_q;
                    alu_funct = FN_SUB;
                    // r_bit set means the shifted remainder exceeds W bits, so it
                    // is certainly >= divisor and the wrapped difference is exact.
                    if (r_bit || alu_res[W]) begin
                        hi_d = alu_res[W-1:0];
                        lo_d = {lo_sh[W-1:1], 1'b1};
                    end else begin
                        hi_d = hi_sh;
                        lo_d = lo_sh;
                    end
                end else begin
                    alu_a     = hi_q;
                    alu_b     = lo_q[0] ? opnd_q : '0;
                    alu_funct = FN_ADD;
                    // Carry-out lands in hi[W-1]; the sum's LSB shifts into lo.
                    hi_d      = alu_res[W:1];
                    lo_d      = {alu_res[0], lo_q[W-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = fix_needed ? StFixLo : StDone;
                end
            end

`ifdef MULDIV_SIGNED_EN
            StFixLo: begin
                busy      = 1'b1;
                alu_a     = '0;
                alu_b     = lo_q;
                alu_funct = FN_SUB;
                if (neg_lo_q) begin
                    lo_d = alu_res[W-1:0];
                end
                state_d   = StFixHi;
            end

            StFixHi: begin
                busy = 1'b1;
                if (div_q) begin
                    alu_a     = '0;
                    alu_b     = hi_q;
                    alu_funct = FN_SUB;
                    if (neg_hi_q) begin
                        hi_d = alu_res[W-1:0];
                    end
                end else begin
                    // 64-bit negate upper half: ~hi plus the carry out of 0-lo,
                    // which is 1 only when lo is zero (negation leaves 0 as 0).
                    alu_a     = ~hi_q;
                    alu_b     = {{(W-1){1'b0}}, (lo_q == '0)};
                    alu_funct = FN_ADD;
                    hi_d      = alu_res[W-1:0];
                end
                state_d = StDone;
            end
`endif

            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            rs_q       <= '0;
            opnd_q     <= '0;
            div_q      <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            rs_q       <= rs_d;
            opnd_q     <= opnd_d;
            div_q      <= div_d;
            div_zero_q <= div_zero_d;
        end
    end

`ifdef MULDIV_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else begin
            sgn_q    <= sgn_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
        end
    end
`endif

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;

endmodule
